jtag_tap_tracker: RTL and testbench



---
 rtl/jtag_tap_tracker.sv | 172 +++++++++++++++++
 tb/tb_jtag_tap_tracker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_tracker.sv
// ============================================================================
//  Module      : jtag_tap_tracker
//  Description : Passive IEEE 1149.1 TAP follower. Synchronises the external
//                TCK/TMS pins, optionally deglitches TCK (JTAG_TAP_FILTER_EN),
//                tracks the 16-state TAP FSM and offers every state change
//                on a valid/ready event port with a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module jtag_tap_tracker #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             jtag_clk,
  input  logic             jtag_tms,
  output logic [3:0]       tap_state,
  output logic             evt_valid,
  output logic [3:0]       evt_state,
  input  logic             evt_ready,
  output logic             evt_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] tck_count
);

  typedef enum logic [3:0] {
    S_TLR     = 4'd0,
    S_RTI     = 4'd1,
    S_SEL_DR  = 4'd2,
    S_CAP_DR  = 4'd3,
    S_SH_DR   = 4'd4,
    S_EX1_DR  = 4'd5,
    S_PAU_DR  = 4'd6,
    S_EX2_DR  = 4'd7,
    S_UPD_DR  = 4'd8,
    S_SEL_IR  = 4'd9,
    S_CAP_IR  = 4'd10,
    S_SH_IR   = 4'd11,
    S_EX1_IR  = 4'd12,
    S_PAU_IR  = 4'd13,
    S_EX2_IR  = 4'd14,
    S_UPD_IR  = 4'd15
  } tap_state_t;

  logic [SYNC_STAGES-1:0] r_tck_sync;
  logic [SYNC_STAGES-1:0] r_tms_sync;
  logic                   w_tck_s;
  logic                   w_tms_s;
  logic                   w_tck_acc;
  logic                   r_tck_prev;
  logic                   w_tck_rise;
  tap_state_t             r_state;
  tap_state_t             w_next;
  logic                   w_evt;

  // Two-or-more flop synchronisers for both asynchronous pins
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], jtag_clk};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], jtag_tms};
    end
  end

  assign w_tck_s = r_tck_sync[SYNC_STAGES-1];
  assign w_tms_s = r_tms_sync[SYNC_STAGES-1];

`ifdef JTAG_TAP_FILTER_EN
  localparam int c_FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILTER_CYCLES - 1);

  logic [c_FW-1:0] r_filt_cnt;
  logic            r_tck_acc;

  // Accept a new TCK level only once it has differed from the accepted
  // level for FILTER_CYCLES consecutive cycles; any bounce restarts the count
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_filt_cnt <= '0;
      r_tck_acc  <= 1'b0;
    end else if (w_tck_s == r_tck_acc) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == c_FILT_LAST) begin
      r_filt_cnt <= '0;
      r_tck_acc  <= w_tck_s;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_tck_acc = r_tck_acc;
`else
  assign w_tck_acc = w_tck_s;
`endif

  // Previous accepted TCK level for rising-edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_tck_prev <= 1'b0;
    else            r_tck_prev <= w_tck_acc;
  end

  assign w_tck_rise = w_tck_acc & ~r_tck_prev;

  // TAP next-state decode from the synchronised TMS
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:    w_next = w_tms_s ? S_TLR    : S_RTI;
      S_RTI:    w_next = w_tms_s ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_next = w_tms_s ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_next = w_tms_s ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_next = w_tms_s ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_next = w_tms_s ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_next = w_tms_s ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_next = w_tms_s ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_next = w_tms_s ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_next = w_tms_s ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_next = w_tms_s ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_next = w_tms_s ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_next = w_tms_s ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_next = w_tms_s ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_next = w_tms_s ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_next = w_tms_s ? S_SEL_DR : S_RTI;
      default:  w_next = S_TLR;
    endcase
  end

  // Self-loops are not reported, only real state changes
  assign w_evt = w_tck_rise && (w_next != r_state);

  // TAP state register and accepted-edge counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_TLR;
      tck_count <= '0;
    end else if (w_tck_rise) begin
      r_state   <= w_next;
      tck_count <= tck_count + 1'b1;
    end
  end

  assign tap_state = r_state;

  // Single-entry event slot: load when empty or draining, otherwise drop
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      evt_valid <= 1'b0;
      evt_state <= 4'd0;
    end else if (w_evt && (!evt_valid || evt_ready)) begin
      evt_valid <= 1'b1;
      evt_state <= w_next;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  // Sticky overflow; a new drop takes priority over a clear request
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                          evt_ovf <= 1'b0;
    else if (w_evt && evt_valid && !evt_ready) evt_ovf <= 1'b1;
    else if (ovf_clr)                        evt_ovf <= 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_tracker.sv
// ============================================================================
//  Module      : tb_jtag_tap_tracker
//  Description : Scoreboard bench for jtag_tap_tracker. Stimulus pushes the
//                hand-derived expected event states into a queue; a monitor
//                pops and compares on every accepted transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jtag_tap_tracker;

  localparam int SYNC_STAGES   = 2;
  localparam int FILTER_CYCLES = 16;
  localparam int CNT_W         = 16;
`ifdef JTAG_TAP_FILTER_EN
  localparam int HOLD     = 40;
  localparam int RISE_DLY = SYNC_STAGES + FILTER_CYCLES;
`else
  localparam int HOLD     = 6;
  localparam int RISE_DLY = SYNC_STAGES;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             jtag_clk = 1'b0;
  logic             jtag_tms = 1'b0;
  logic [3:0]       tap_state;
  logic             evt_valid;
  logic [3:0]       evt_state;
  logic             evt_ready = 1'b0;
  logic             evt_ovf;
  logic             ovf_clr = 1'b0;
  logic [CNT_W-1:0] tck_count;

  int        n_checks = 0;
  int        n_fail   = 0;
  logic [3:0] exp_q[$];

  jtag_tap_tracker #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .jtag_clk (jtag_clk),
    .jtag_tms (jtag_tms),
    .tap_state(tap_state),
    .evt_valid(evt_valid),
    .evt_state(evt_state),
    .evt_ready(evt_ready),
    .evt_ovf  (evt_ovf),
    .ovf_clr  (ovf_clr),
    .tck_count(tck_count)
  );

  always #18 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // One full TCK period with TMS set up well ahead of the rising edge
  task automatic tck_pulse(input logic tms);
    jtag_tms = tms;
    cycles(4);
    jtag_clk = 1'b1;
    cycles(HOLD);
    jtag_clk = 1'b0;
    cycles(HOLD);
  endtask

  // Monitor: every transfer must match the head of the expected queue
  always @(negedge sys_clk) begin
    if (sys_rst_n && evt_valid && evt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got state %0d with empty queue", evt_state);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (evt_state !== e) begin
          n_fail++;
          $display("FAIL event_state: got %0d expected %0d", evt_state, e);
        end
      end
    end
  end

  initial begin
    // Reset state
    cycles(3);
    check("rst_tap_state", tap_state, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_state", evt_state, 0);
    check("rst_evt_ovf",   evt_ovf,   0);
    check("rst_tck_count", tck_count, 0);
    sys_rst_n = 1'b1;
    evt_ready = 1'b1;
    cycles(2);

    // 1: five TMS=1 edges stay in TLR silently, then TMS=0 -> RTI
    for (int i = 0; i < 5; i++) tck_pulse(1'b1);
    check("t1_tlr_hold", tap_state, 0);
    exp_q.push_back(4'd1);
    tck_pulse(1'b0);
    check("t1_tap_state", tap_state, 1);
    check("t1_tck_count", tck_count, 6);

    // 2: RTI, TMS 1,0,0,0,1,1 -> 2,3,4,(4),5,8
    exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4);
    exp_q.push_back(4'd5); exp_q.push_back(4'd8);
    tck_pulse(1'b1); tck_pulse(1'b0); tck_pulse(1'b0);
    tck_pulse(1'b0); tck_pulse(1'b1); tck_pulse(1'b1);
    check("t2_tap_state", tap_state, 8);
    check("t2_evt_ovf",   evt_ovf,   0);
    check("t2_tck_count", tck_count, 12);
    check("t2_drained",   exp_q.size(), 0);

    // 3: back to RTI, then stall the consumer across two changes
    exp_q.push_back(4'd1);
    tck_pulse(1'b0);
    evt_ready = 1'b0;
    exp_q.push_back(4'd2);
    tck_pulse(1'b1);
    check("t3_ovf_first", evt_ovf, 0);
    tck_pulse(1'b1);                 // SEL_IR event dropped
    check("t3_tap_state", tap_state, 9);
    check("t3_evt_valid", evt_valid, 1);
    check("t3_evt_state", evt_state, 2);
    check("t3_evt_ovf",   evt_ovf,   1);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    cycles(1);
    check("t3_ovf_clr",       evt_ovf,   0);
    check("t3_state_after",   evt_state, 2);

    // 4: release ready in the very cycle the next edge is accepted
    exp_q.push_back(4'd10);
    jtag_tms = 1'b0;
    cycles(4);
    jtag_clk = 1'b1;
    cycles(RISE_DLY);
    evt_ready = 1'b1;                // tck_rise is high during this cycle
    cycles(1);
    check("t4_valid_kept", evt_valid, 1);
    check("t4_new_state",  evt_state, 10);
    check("t4_no_ovf",     evt_ovf,   0);
    cycles(HOLD);
    jtag_clk = 1'b0;
    cycles(HOLD);
    check("t4_tap_state", tap_state, 10);
    check("t4_tck_count", tck_count, 16);
    check("t4_drained",   exp_q.size(), 0);

`ifdef JTAG_TAP_FILTER_EN
    // 5: short TCK glitch must be rejected by the filter
    jtag_tms = 1'b0;
    cycles(4);
    jtag_clk = 1'b1;
    cycles(5);
    jtag_clk = 1'b0;
    cycles(40);
    check("t5_glitch_state", tap_state, 10);
    check("t5_glitch_count", tck_count, 16);
`endif

    // TMS activity without any TCK edge is ignored
    for (int i = 0; i < 6; i++) begin
      jtag_tms = ~jtag_tms;
      cycles(5);
    end
    check("tms_only_state", tap_state, 10);
    check("tms_only_count", tck_count, 16);

    // 6: enter SH_IR with the event left pending, then reset mid-flight
    evt_ready = 1'b0;
    exp_q.push_back(4'd11);
    tck_pulse(1'b0);
    check("t6_tap_state", tap_state, 11);
    check("t6_pending",   evt_valid, 1);
    #5;
    sys_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_tap_state", tap_state, 0);
    check("t6_rst_evt_valid", evt_valid, 0);
    check("t6_rst_tck_count", tck_count, 0);
    check("t6_rst_evt_ovf",   evt_ovf,   0);
    cycles(2);
    sys_rst_n = 1'b1;
    evt_ready = 1'b1;
    cycles(10);
    check("t6_post_valid", evt_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
